memory_bus_unit: RTL and testbench
==================================

// Module: memory_bus_unit
// PURPOSE
//  Datapath responder for the control sequencer's strobes. Holds the memory address register (MAR),
//  program/data RAM and instruction register (IR), and drives the shared bus when selected.
//  Also provides a valid/ready program-loader port, usable only while the CPU is halted.
//  Clears RAM after every reset.
// PARAMETERS
//  DATA_W   8  bus, RAM word and IR width; opcode = IR[DATA_W-1:DATA_W-3]
//  ADDR_W   4  MAR/operand width; RAM depth = 2**ADDR_W
// PORTS
//  clk            in   1                   system clock, all state on posedge
//  bReset         in   1                   synchronous, active-high reset
//  bus_in         in   DATA_W              shared bus value
//  bus_selector   in   `BusSelectorBits    current bus source from control
//  memory_in      in   1                   load MAR from bus_in[ADDR_W-1:0]
//  ram_in         in   1                   write bus_in to RAM[MAR]
//  instruction_in in   1                   load IR from bus_in
//  hlt            in   1                   CPU halted; gates entry to LOAD
//  prog_mode      in   1                   request program-load mode
//  ld_valid       in   1                   loader word valid
//  ld_addr        in   ADDR_W              loader target address
//  ld_data        in   DATA_W              loader word
//  ld_ready       out  1                   loader may transfer this cycle
//  ld_count       out  ADDR_W+1            words accepted since LOAD entry, saturating
//  busy           out  1                   high in CLEAR
//  bus_out        out  DATA_W              value driven onto bus
//  bus_drive      out  1                   bus_out is valid this cycle
//  instruction    out  DATA_W              IR contents to control
//  mar            out  ADDR_W              MAR contents (debug)
// BEHAVIOUR
//  Reset (bReset=1 at posedge): MAR=0, IR=0, ld_count=0, clr_cnt=0, state=CLEAR. RAM contents are not reset directly.
//   busy=1, ld_ready=0, bus_drive=0, bus_out=0. Reset in any state, including mid-CLEAR or mid-LOAD, restarts CLEAR at address 0.
//  FSM states: CLEAR, RUN, LOAD.
//  CLEAR:
//   - Each cycle: RAM[clr_cnt] <= 0, clr_cnt++.
//   - After 2**ADDR_W cycles (clr_cnt wraps to 0): go to LOAD if prog_mode else RUN.
//   - All strobes and ld_valid are ignored; busy=1.
//  RUN:
//   - memory_in: MAR <= bus_in[ADDR_W-1:0].
//   - ram_in: RAM[MAR] <= bus_in, using the pre-edge MAR. memory_in and ram_in together write the old
//     address and also update MAR.
//   - instruction_in: IR <= bus_in. It may coincide with memory_in; both capture the same bus_in.
//   - RUN->LOAD when prog_mode & hlt. On entry ld_count <= 0. prog_mode without hlt stays in RUN.
//  LOAD:
//   - ld_ready=1. Transfer on ld_valid & ld_ready: RAM[ld_addr] <= ld_data.
//   - ld_count++ per transfer, saturating at 2**ADDR_W.
//   - memory_in, ram_in and instruction_in are ignored; bus_drive=0.
//   - LOAD->RUN when prog_mode=0. A transfer presented in that same cycle is still accepted, since ld_ready is
//     registered from state. MAR=0 and IR=0 on exit so the fetch starts at address 0.
//  Bus output (combinational, RUN only):
//   - bus_selector==`BUS_RAM: bus_out = RAM[MAR] (asynchronous read), bus_drive=1.
//   - bus_selector==`BUS_IR:  bus_out = {0, IR[ADDR_W-1:0]}, bus_drive=1.
//   - Any other selector, or CLEAR/LOAD: bus_out=0, bus_drive=0.
//   - The read reflects RAM before any same-edge write (read-before-write).
//  Widths: upper bus_in bits above ADDR_W are discarded for MAR. No arithmetic besides the clr_cnt and ld_count increments.
// STRUCTURE
//  Shared parameters include (src/parameters.v):
//   - `BusSelectorBits and bus-source codes `BUS_NONE, `BUS_PC, `BUS_RAM, `BUS_IR, `BUS_A, `BUS_ALU
//   - FSM codes `MBU_CLEAR, `MBU_RUN, `MBU_LOAD
//  Sub-module memory_ram: 2**ADDR_W x DATA_W register array with one synchronous write port and one
//  asynchronous read port. The write port is muxed by state: clear / control / loader.
// TESTING
//  1. Reset, hold 16 cycles -> busy=1 for exactly 16 cycles; then RUN; every RAM[i]==0 via BUS_RAM reads.
//  2. RUN: bus_in=8'h0A + memory_in; bus_in=8'h5C + ram_in; bus_selector=BUS_RAM -> bus_out=8'h5C, bus_drive=1, mar=4'hA.
//  3. MAR=3, then same cycle bus_in=8'h07 with memory_in+ram_in -> RAM[3]=8'h07, RAM[7] unchanged, mar=7.
//  4. bus_in=8'hE9 + instruction_in -> instruction=8'hE9; BUS_IR -> bus_out=8'h09.
//  5. prog_mode=1, hlt=0 -> stays RUN, ld_ready=0. Raise hlt -> LOAD, ld_ready=1. Stream 18 words with gaps in
//     ld_valid -> ld_count saturates at 16, last write per address wins. Drop prog_mode -> RUN, mar=0, instruction=0.
//  6. bReset mid-LOAD (after 5 words) and mid-CLEAR (clr_cnt=9) -> CLEAR restarts at 0, 16 busy cycles,
//     loaded words are zeroed.

Source files
------------

// File: rtl/memory_bus_unit_pkg.sv
// Shared definitions for the memory bus unit: bus-source selector codes
// driven by the control sequencer, and the unit's FSM states.
package memory_bus_unit_pkg;

    localparam int unsigned BUS_SEL_W = 3;

    typedef enum logic [BUS_SEL_W-1:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_RAM  = 3'd2,
        BUS_IR   = 3'd3,
        BUS_A    = 3'd4,
        BUS_ALU  = 3'd5
    } bus_sel_e;

    typedef enum logic [1:0] {
        MBU_CLEAR = 2'd0,
        MBU_RUN   = 2'd1,
        MBU_LOAD  = 2'd2
    } mbu_state_e;

endpackage

// File: rtl/memory_bus_unit_ram.sv
// memory_ram: 2**ADDR_W x DATA_W register array.
//   clk    - write clock
//   we     - write enable (synchronous)
//   waddr  - write address
//   wdata  - write data
//   raddr  - asynchronous read address
//   rdata  - read data; reflects contents before a same-edge write
module memory_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_bus_unit.sv
// memory_bus_unit: MAR, program/data RAM and IR responding to the control
// sequencer's strobes, plus a valid/ready program loader usable while halted.
// RAM is zeroed after every reset (CLEAR state, busy=1).
//   clk, bReset      - clock, synchronous active-high reset
//   bus_in           - shared bus value
//   bus_selector     - current bus source
//   memory_in        - load MAR from bus_in low bits
//   ram_in           - write bus_in to RAM[MAR]
//   instruction_in   - load IR from bus_in
//   hlt, prog_mode   - CPU halted / request program-load mode
//   ld_valid/addr/data, ld_ready, ld_count - loader handshake and word count
//   busy             - RAM clear in progress
//   bus_out, bus_drive - value driven onto the bus and its valid flag
//   instruction, mar - IR and MAR contents
module memory_bus_unit
    import memory_bus_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 bReset,
    input  logic [DATA_W-1:0]    bus_in,
    input  logic [BUS_SEL_W-1:0] bus_selector,
    input  logic                 memory_in,
    input  logic                 ram_in,
    input  logic                 instruction_in,
    input  logic                 hlt,
    input  logic                 prog_mode,
    input  logic                 ld_valid,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    output logic [ADDR_W:0]      ld_count,
    output logic                 busy,
    output logic [DATA_W-1:0]    bus_out,
    output logic                 bus_drive,
    output logic [DATA_W-1:0]    instruction,
    output logic [ADDR_W-1:0]    mar
);

    localparam logic [ADDR_W:0] LD_MAX = {1'b1, {ADDR_W{1'b0}}};

    mbu_state_e        state, state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W:0]   ld_cnt_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (bReset) begin
            state <= MBU_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MBU_CLEAR: if (clr_cnt == '1) state_next = prog_mode ? MBU_LOAD : MBU_RUN;
            MBU_RUN:   if (prog_mode && hlt) state_next = MBU_LOAD;
            MBU_LOAD:  if (!prog_mode) state_next = MBU_RUN;
            default:   state_next = MBU_CLEAR;
        endcase
    end

    // Single RAM write port shared by clear, control strobes and loader.
    // Writes are suppressed during reset so a strobe or loader word that
    // coincides with reset cannot land in RAM.
    always_comb begin
        we        = 1'b0;
        waddr     = clr_cnt;
        wdata     = '0;
        busy      = 1'b0;
        ld_ready  = 1'b0;
        bus_out   = '0;
        bus_drive = 1'b0;
        case (state)
            MBU_CLEAR: begin
                we   = 1'b1;
                busy = 1'b1;
            end
            MBU_RUN: begin
                we    = ram_in;
                waddr = mar_q;
                wdata = bus_in;
                if (bus_selector == BUS_RAM) begin
                    bus_out   = rdata;
                    bus_drive = 1'b1;
                end else if (bus_selector == BUS_IR) begin
                    bus_out[ADDR_W-1:0] = ir_q[ADDR_W-1:0];
                    bus_drive           = 1'b1;
                end
            end
            MBU_LOAD: begin
                ld_ready = 1'b1;
                we       = ld_valid;
                waddr    = ld_addr;
                wdata    = ld_data;
            end
            default: ;
        endcase
        if (bReset) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (bReset) begin
            clr_cnt  <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            ld_cnt_q <= '0;
        end else begin
            case (state)
                MBU_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (state_next == MBU_LOAD) ld_cnt_q <= '0;
                end
                MBU_RUN: begin
                    if (memory_in)      mar_q <= bus_in[ADDR_W-1:0];
                    if (instruction_in) ir_q  <= bus_in;
                    if (state_next == MBU_LOAD) ld_cnt_q <= '0;
                end
                MBU_LOAD: begin
                    if (ld_valid && (ld_cnt_q != LD_MAX)) begin
                        ld_cnt_q <= ld_cnt_q + (ADDR_W+1)'(1);
                    end
                    // Fetch restarts from address 0 after a program load.
                    if (state_next == MBU_RUN) begin
                        mar_q <= '0;
                        ir_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    memory_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (mar_q),
        .rdata (rdata)
    );

    assign ld_count    = ld_cnt_q;
    assign instruction = ir_q;
    assign mar         = mar_q;

endmodule

// File: tb/tb_memory_bus_unit.sv
module tb_memory_bus_unit;

    logic       clk = 1'b0;
    logic       bReset;
    logic [7:0] bus_in;
    logic [2:0] bus_selector;
    logic       memory_in, ram_in, instruction_in, hlt, prog_mode;
    logic       ld_valid;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [4:0] ld_count;
    logic       busy;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [7:0] instruction;
    logic [3:0] mar;

    int compared   = 0;
    int mismatched = 0;

    memory_bus_unit #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk            (clk),
        .bReset         (bReset),
        .bus_in         (bus_in),
        .bus_selector   (bus_selector),
        .memory_in      (memory_in),
        .ram_in         (ram_in),
        .instruction_in (instruction_in),
        .hlt            (hlt),
        .prog_mode      (prog_mode),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .ld_count       (ld_count),
        .busy           (busy),
        .bus_out        (bus_out),
        .bus_drive      (bus_drive),
        .instruction    (instruction),
        .mar            (mar)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles of clearing left, a loading flag, and the
    // architectural registers/memory.
    int         clear_left;
    bit         loading;
    logic [7:0] ram_m [16];
    logic [3:0] mar_m;
    logic [7:0] ir_m;
    int         cnt_m;

    function automatic logic [27:0] exp_out();
        logic       e_busy, e_rdy, e_drv;
        logic [7:0] e_bus;
        e_busy = (clear_left > 0);
        e_rdy  = !e_busy && loading;
        e_drv  = 1'b0;
        e_bus  = 8'h00;
        if (!e_busy && !loading) begin
            if (bus_selector == 3'd2) begin e_drv = 1'b1; e_bus = ram_m[mar_m]; end
            if (bus_selector == 3'd3) begin e_drv = 1'b1; e_bus = {4'h0, ir_m[3:0]}; end
        end
        return {e_busy, e_rdy, 5'(cnt_m), e_drv, e_bus, ir_m, mar_m};
    endfunction

    function automatic logic [27:0] obs_out();
        return {busy, ld_ready, ld_count, bus_drive, bus_out, instruction, mar};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (bReset) begin
            clear_left = 16; loading = 0; mar_m = 0; ir_m = 0; cnt_m = 0;
        end else if (clear_left > 0) begin
            ram_m[16 - clear_left] = 8'h00;
            clear_left--;
            if (clear_left == 0) begin loading = prog_mode; cnt_m = 0; end
        end else if (loading) begin
            if (ld_valid) begin
                ram_m[ld_addr] = ld_data;
                if (cnt_m < 16) cnt_m++;
            end
            if (!prog_mode) begin loading = 0; mar_m = 0; ir_m = 0; end
        end else begin
            if (ram_in)         ram_m[mar_m] = bus_in;
            if (memory_in)      mar_m = bus_in[3:0];
            if (instruction_in) ir_m = bus_in;
            if (prog_mode && hlt) begin loading = 1; cnt_m = 0; end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus_in = 8'h00; bus_selector = 3'd0; memory_in = 0; ram_in = 0;
        instruction_in = 0; ld_valid = 0; ld_addr = 4'h0; ld_data = 8'h00;
    endtask

    task automatic test_reset();
        int busy_cycles;
        bReset = 1; hlt = 0; prog_mode = 0; idle_inputs();
        repeat (16) tick();
        #1;
        compared++;
        if (obs_out() !== {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 4'h0}) begin
            mismatched++; $display("FAIL reset_state: got %h required %h", obs_out(), {1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 4'h0});
        end
        bReset = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        compared++;
        if (busy_cycles != 16) begin
            mismatched++; $display("FAIL reset_busy_len: got %0d required 16", busy_cycles);
        end
        for (int i = 0; i < 16; i++) begin
            bus_in = 8'(i); memory_in = 1; bus_selector = 3'd0;
            tick();
            memory_in = 0; bus_selector = 3'd2; #1;
            compared++;
            if (bus_out !== 8'h00 || bus_drive !== 1'b1 || obs_out() !== exp_out()) begin
                mismatched++; $display("FAIL clear_ram[%0d]: got %h required %h", i, obs_out(), exp_out());
            end
        end
    endtask

    task automatic test_run_write();
        idle_inputs();
        bus_in = 8'h0A; memory_in = 1; tick();
        memory_in = 0; bus_in = 8'h5C; ram_in = 1; tick();
        ram_in = 0; bus_selector = 3'd2; #1;
        compared++;
        if (bus_out !== 8'h5C || bus_drive !== 1'b1 || mar !== 4'hA) begin
            mismatched++; $display("FAIL run_write: got bus=%h drv=%b mar=%h required 5c 1 a", bus_out, bus_drive, mar);
        end
    endtask

    task automatic test_mar_same_cycle();
        logic [7:0] old7;
        idle_inputs();
        bus_in = 8'h03; memory_in = 1; tick();
        old7 = ram_m[7];
        bus_in = 8'h07; ram_in = 1; tick();
        idle_inputs(); bus_selector = 3'd2; #1;
        compared++;
        if (mar !== 4'h7 || bus_out !== old7) begin
            mismatched++; $display("FAIL mar_ram_same: got mar=%h ram7=%h required 7 %h", mar, bus_out, old7);
        end
        bus_in = 8'h03; memory_in = 1; tick();
        memory_in = 0; #1;
        compared++;
        if (bus_out !== 8'h07) begin
            mismatched++; $display("FAIL ram3_old_addr: got %h required 07", bus_out);
        end
    endtask

    task automatic test_ir();
        idle_inputs();
        bus_in = 8'hE9; instruction_in = 1; tick();
        instruction_in = 0; bus_selector = 3'd3; #1;
        compared++;
        if (instruction !== 8'hE9 || bus_out !== 8'h09 || bus_drive !== 1'b1) begin
            mismatched++; $display("FAIL ir_load: got ir=%h bus=%h drv=%b required e9 09 1", instruction, bus_out, bus_drive);
        end
    endtask

    task automatic test_load();
        int transfers;
        idle_inputs();
        prog_mode = 1; hlt = 0; tick(); #1;
        compared++;
        if (ld_ready !== 1'b0 || obs_out() !== exp_out()) begin
            mismatched++; $display("FAIL load_no_hlt: got %h required %h", obs_out(), exp_out());
        end
        hlt = 1; tick(); #1;
        compared++;
        if (ld_ready !== 1'b1 || ld_count !== 5'd0) begin
            mismatched++; $display("FAIL load_entry: got rdy=%b cnt=%0d required 1 0", ld_ready, ld_count);
        end
        transfers = 0;
        for (int c = 0; c < 300 && transfers < 18; c++) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            ld_addr  = 4'($urandom_range(0, 15));
            ld_data  = 8'($urandom);
            memory_in = 1; ram_in = 1; instruction_in = 1; bus_in = 8'($urandom);
            bus_selector = 3'd2; #1;
            compared++;
            if (obs_out() !== exp_out()) begin
                mismatched++; $display("FAIL load_stream: got %h required %h", obs_out(), exp_out());
            end
            if (ld_valid) transfers++;
            tick();
        end
        idle_inputs(); #1;
        compared++;
        if (ld_count !== 5'd16 || transfers != 18) begin
            mismatched++; $display("FAIL load_saturate: got cnt=%0d xfers=%0d required 16 18", ld_count, transfers);
        end
        // Word offered in the exit cycle must still be written.
        prog_mode = 0; ld_valid = 1; ld_addr = 4'h5; ld_data = 8'hA5; tick();
        idle_inputs(); #1;
        compared++;
        if (mar !== 4'h0 || instruction !== 8'h00 || ld_ready !== 1'b0 || obs_out() !== exp_out()) begin
            mismatched++; $display("FAIL load_exit: got %h required %h", obs_out(), exp_out());
        end
        for (int i = 0; i < 16; i++) begin
            bus_in = 8'(i); memory_in = 1; tick();
            memory_in = 0; bus_selector = 3'd2; #1;
            compared++;
            if (obs_out() !== exp_out() || (i == 5 && bus_out !== 8'hA5)) begin
                mismatched++; $display("FAIL load_readback[%0d]: got %h required %h", i, obs_out(), exp_out());
            end
            bus_selector = 3'd0;
        end
    endtask

    task automatic test_reset_midway();
        int busy_cycles;
        idle_inputs();
        prog_mode = 1; hlt = 1; tick();
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_addr = 4'(i + 2); ld_data = 8'(8'h80 + i); tick();
        end
        idle_inputs(); #1;
        compared++;
        if (ld_count !== 5'd5) begin
            mismatched++; $display("FAIL midload_count: got %0d required 5", ld_count);
        end
        prog_mode = 0; hlt = 0;
        bReset = 1; tick(); bReset = 0;
        repeat (9) tick();
        #1;
        compared++;
        if (busy !== 1'b1 || obs_out() !== exp_out()) begin
            mismatched++; $display("FAIL midclear_busy: got %h required %h", obs_out(), exp_out());
        end
        bReset = 1; tick(); bReset = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
        compared++;
        if (busy_cycles != 16) begin
            mismatched++; $display("FAIL midclear_restart: got %0d busy cycles required 16", busy_cycles);
        end
        for (int i = 0; i < 16; i++) begin
            bus_in = 8'(i); memory_in = 1; tick();
            memory_in = 0; bus_selector = 3'd2; #1;
            compared++;
            if (bus_out !== 8'h00 || obs_out() !== exp_out()) begin
                mismatched++; $display("FAIL reclear_ram[%0d]: got %h required 00", i, bus_out);
            end
            bus_selector = 3'd0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bReset         = ($urandom_range(0, 199) == 0);
            bus_in         = 8'($urandom);
            bus_selector   = 3'($urandom_range(0, 7));
            memory_in      = ($urandom_range(0, 2) == 0);
            ram_in         = ($urandom_range(0, 2) == 0);
            instruction_in = ($urandom_range(0, 3) == 0);
            hlt            = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 19) == 0) prog_mode = !prog_mode;
            ld_valid       = ($urandom_range(0, 1) == 0);
            ld_addr        = 4'($urandom);
            ld_data        = 8'($urandom);
            #1;
            compared++;
            if (obs_out() !== exp_out()) begin
                mismatched++; $display("FAIL random[%0d]: got %h required %h", c, obs_out(), exp_out());
            end
            tick();
        end
        bReset = 0;
    endtask

    initial begin
        test_reset();
        test_run_write();
        test_mar_same_cycle();
        test_ir();
        test_load();
        test_reset_midway();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
